// File: rtl/div_result_bcd.sv
// div_result_bcd: captures a quotient/remainder pair and converts both to packed BCD
// with a sequential double-dabble engine behind valid/ready handshakes.
module div_result_bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quotient,
    input  logic [WIDTH-1:0]    remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] q_bin, r_bin;
    logic [BW-1:0]    q_acc, r_acc, q_adj, r_adj, q_nxt, r_nxt;
    logic [CW-1:0]    count;
    logic             last;

    // Digits are corrected independently; no carry ripples between them.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] a;
        a = b;
        for (int i = 0; i < DIGITS; i++)
            a[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
        return a;
    endfunction

    always_comb begin
        q_adj   = add3(q_acc);
        r_adj   = add3(r_acc);
        q_nxt   = {q_adj[BW-2:0], q_bin[WIDTH-1]};
        r_nxt   = {r_adj[BW-2:0], r_bin[WIDTH-1]};
        last    = count == CW'(WIDTH - 1);
        state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
                  state == SHIFT ? (last ? DONE : SHIFT) :
                                   (out_ready ? IDLE : DONE);
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_bin <= '0;
            r_bin <= '0;
            q_acc <= '0;
            r_acc <= '0;
            count <= '0;
            q_bcd <= '0;
            r_bcd <= '0;
        end else if (state == IDLE && in_valid) begin
            q_bin <= quotient;
            r_bin <= remainder;
            q_acc <= '0;
            r_acc <= '0;
            count <= '0;
        end else if (state == SHIFT) begin
            q_acc <= q_nxt;
            r_acc <= r_nxt;
            q_bin <= q_bin << 1;
            r_bin <= r_bin << 1;
            count <= count + CW'(1);
            if (last) begin
                q_bcd <= q_nxt;
                r_bcd <= r_nxt;
            end
        end
    end
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed and randomized checks of div_result_bcd against a
// decimal-digit reference model.
module tb_div_result_bcd;
    logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [15:0] quotient = 0, remainder = 0;
    logic [19:0] q_bcd, r_bcd;
    int          checks = 0, failures = 0;

    div_result_bcd dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .quotient(quotient), .remainder(remainder), .out_valid(out_valid),
        .out_ready(out_ready), .q_bcd(q_bcd), .r_bcd(r_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] res;
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            res[4*i+:4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_q_bcd", 32'(q_bcd), 0);
        check("rst_r_bcd", 32'(r_bcd), 0);
    endtask

    // Counts edges from acceptance to out_valid and checks the converted values.
    task automatic wait_done(input int q, input int r, input bit watch_ready);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
            if (watch_ready && !out_valid) check("busy_in_ready", 32'(in_ready), 0);
        end
        check("latency", n, 16);
        check("q_bcd", 32'(q_bcd), 32'(to_bcd(q)));
        check("r_bcd", 32'(r_bcd), 32'(to_bcd(r)));
    endtask

    task automatic accept(input int q, input int r);
        int n;
        n = 0;
        quotient  = 16'(q);
        remainder = 16'(r);
        in_valid  = 1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
    endtask

    task automatic handshake();
        out_ready = 1;
        tick();
        out_ready = 0;
        check("hs_out_valid", 32'(out_valid), 0);
        check("hs_in_ready", 32'(in_ready), 1);
    endtask

    task automatic convert(input int q, input int r);
        accept(q, r);
        wait_done(q, r, 0);
        handshake();
    endtask

    initial begin
        logic [19:0] hq, hr;
        int q, r, d;
        do_reset();
        convert(10, 0);
        convert(16'hFFFF, 10);
        check("max_q_bcd", 32'(q_bcd), 32'h65535);

        accept(777, 42);
        wait_done(777, 42, 1);
        hq = q_bcd;
        hr = r_bcd;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_q", 32'(q_bcd), 32'(hq));
            check("hold_r", 32'(r_bcd), 32'(hr));
        end
        handshake();
        check("post_hs_q", 32'(q_bcd), 32'(hq));

        quotient = 5; remainder = 1; in_valid = 1;
        tick();
        quotient = 9999; remainder = 3;
        wait_done(5, 1, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("stream_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        check("stream_busy", 32'(in_ready), 0);
        check("stream_q_kept", 32'(q_bcd), 32'h00005);
        wait_done(9999, 3, 1);
        handshake();

        accept(4321, 99);
        for (int i = 0; i < 7; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_q", 32'(q_bcd), 0);
        check("midrst_r", 32'(r_bcd), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        convert(1234, 56);
        convert(0, 0);

        for (int k = 0; k < 25; k++) begin
            q = int'($urandom_range(0, 65535));
            r = int'($urandom_range(0, 65535));
            accept(q, r);
            wait_done(q, r, 0);
            d = int'($urandom_range(0, 3));
            for (int i = 0; i < d; i++) begin
                out_ready = 0;
                tick();
                check("rand_hold", 32'(out_valid), 1);
            end
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
